fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 55 +++++
 tb/tb_fifo_uart_tx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an upstream FIFO and sends them as 8N1 serial frames, LSB first.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        EMP,
  input  logic [7:0]  read_data,
  output logic        read_req,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frame_count
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic last;
  always_comb begin
    last = cnt == CW'(CLKS_PER_BIT - 1);
    read_req = reset & enable & ~EMP & (state == IDLE | (state == STOP & last));
    busy = state != IDLE;
    tx = state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = read_req ? FETCH : IDLE;
      FETCH:   state_nxt = START;
      START:   state_nxt = last ? DATA : START;
      DATA:    state_nxt = last && bit_idx == 3'd7 ? STOP : DATA;
      STOP:    state_nxt = !last ? STOP : read_req ? FETCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      frame_count <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == START || state == DATA || state == STOP) && !last ? cnt + 1'b1 : '0;
      if (state == FETCH) shreg <= read_data;
      if (state == DATA && last) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 1'b1;
      end
      if (state == STOP && last) frame_count <= frame_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed checks of fifo_uart_tx at 4 clocks per bit against a small FIFO model.
module tb_fifo_uart_tx;
  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic reset, enable, EMP, read_req, tx, busy;
  logic [7:0] read_data = 8'h00;
  logic [15:0] frame_count;
  logic [7:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int total = 0;
  int bad = 0;
  int run = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .EMP(EMP), .read_data(read_data),
    .read_req(read_req), .tx(tx), .busy(busy), .frame_count(frame_count)
  );

  always #5 if (clk_run) clk = ~clk;

  assign EMP = wr_ptr == rd_ptr;
  always @(posedge clk) if (read_req) begin
    read_data <= mem[rd_ptr % 16];
    rd_ptr <= rd_ptr + 1;
  end

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 16] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  // k counts cycles after the read_req cycle: 1 = FETCH, then 10 bits of 4 cycles
  function automatic logic exp_tx(input logic [7:0] d, input int k);
    int i;
    i = (k - 2) / 4;
    if (k < 2) return 1'b1;
    return i == 0 ? 1'b0 : i <= 8 ? d[i-1] : 1'b1;
  endfunction

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0;
    #2 reset = 1'b0;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b want=1", tx); end
    total++; if (read_req !== 1'b0) begin bad++; $display("FAIL rst_rr got=%b want=0", read_req); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (frame_count !== 16'h0) begin bad++; $display("FAIL rst_fc got=%h want=0000", frame_count); end
    clk_run = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1; enable = 1'b1;
  endtask

  task automatic test_idle_empty;
    repeat (100) begin
      @(negedge clk);
      total++; if (read_req !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) begin
        bad++; $display("FAIL empty rr/tx/busy got=%b%b%b want=010", read_req, tx, busy);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    push(8'h3C); push(8'h81);
    #1;
    total++; if (read_req !== 1'b1) begin bad++; $display("FAIL rm_rr0 got=%b want=1", read_req); end
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      total++; if (tx !== exp_tx(8'h3C, k)) begin bad++; $display("FAIL rm_tx k=%0d got=%b want=%b", k, tx, exp_tx(8'h3C, k)); end
    end
    reset = 1'b0;
    #1;
    total++; if (tx !== 1'b1 || busy !== 1'b0 || read_req !== 1'b0) begin
      bad++; $display("FAIL rm_async tx/busy/rr got=%b%b%b want=100", tx, busy, read_req);
    end
    total++; if (frame_count !== 16'h0) begin bad++; $display("FAIL rm_fc got=%h want=0000", frame_count); end
    repeat (2) begin
      @(negedge clk);
      total++; if (read_req !== 1'b0 || tx !== 1'b1) begin bad++; $display("FAIL rm_hold rr/tx got=%b%b want=01", read_req, tx); end
    end
    reset = 1'b1;
    #1;
    total++; if (read_req !== 1'b1) begin bad++; $display("FAIL rm_rr1 got=%b want=1", read_req); end
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      total++; if (tx !== exp_tx(8'h81, k)) begin bad++; $display("FAIL rm81_tx k=%0d got=%b want=%b", k, tx, exp_tx(8'h81, k)); end
      total++; if (read_req !== 1'b0) begin bad++; $display("FAIL rm81_rr k=%0d got=%b want=0", k, read_req); end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0 || frame_count !== 16'd1) begin
      bad++; $display("FAIL rm81_end busy=%b fc=%0d want busy=0 fc=1", busy, frame_count);
    end
  endtask

  task automatic test_single_a5;
    push(8'hA5);
    #1;
    total++; if (read_req !== 1'b1) begin bad++; $display("FAIL a5_rr0 got=%b want=1", read_req); end
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      total++; if (tx !== exp_tx(8'hA5, k)) begin bad++; $display("FAIL a5_tx k=%0d got=%b want=%b", k, tx, exp_tx(8'hA5, k)); end
      total++; if (busy !== 1'b1 || read_req !== 1'b0) begin bad++; $display("FAIL a5_busy_rr k=%0d got=%b%b want=10", k, busy, read_req); end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0 || tx !== 1'b1) begin bad++; $display("FAIL a5_end busy/tx got=%b%b want=01", busy, tx); end
    total++; if (frame_count !== 16'd2) begin bad++; $display("FAIL a5_fc got=%0d want=2", frame_count); end
  endtask

  task automatic test_back_to_back;
    push(8'h00); push(8'hFF);
    #1;
    total++; if (read_req !== 1'b1) begin bad++; $display("FAIL b2b_rr0 got=%b want=1", read_req); end
    run = 0;
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      total++; if (tx !== exp_tx(8'h00, k)) begin bad++; $display("FAIL b2b0_tx k=%0d got=%b want=%b", k, tx, exp_tx(8'h00, k)); end
      total++; if (read_req !== (k == 41)) begin bad++; $display("FAIL b2b0_rr k=%0d got=%b want=%b", k, read_req, k == 41); end
      run = tx ? run + 1 : 0;
    end
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      if (k == 2) begin
        total++; if (run !== 5) begin bad++; $display("FAIL b2b_gap got=%0d want=5", run); end
      end
      total++; if (tx !== exp_tx(8'hFF, k)) begin bad++; $display("FAIL b2b1_tx k=%0d got=%b want=%b", k, tx, exp_tx(8'hFF, k)); end
      total++; if (read_req !== 1'b0) begin bad++; $display("FAIL b2b1_rr k=%0d got=%b want=0", k, read_req); end
      run = tx ? run + 1 : 0;
    end
    @(negedge clk);
    total++; if (frame_count !== 16'd4 || EMP !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_end fc=%0d EMP=%b busy=%b want fc=4 EMP=1 busy=0", frame_count, EMP, busy);
    end
  endtask

  task automatic test_enable_drop;
    push(8'h5A); push(8'hC3);
    #1;
    total++; if (read_req !== 1'b1) begin bad++; $display("FAIL en_rr0 got=%b want=1", read_req); end
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      total++; if (tx !== exp_tx(8'h5A, k)) begin bad++; $display("FAIL en_tx k=%0d got=%b want=%b", k, tx, exp_tx(8'h5A, k)); end
      total++; if (read_req !== 1'b0) begin bad++; $display("FAIL en_rr k=%0d got=%b want=0", k, read_req); end
      if (k == 15) enable = 1'b0;
    end
    repeat (20) begin
      @(negedge clk);
      total++; if (read_req !== 1'b0 || busy !== 1'b0 || EMP !== 1'b0 || tx !== 1'b1) begin
        bad++; $display("FAIL en_after rr/busy/EMP/tx got=%b%b%b%b want=0001", read_req, busy, EMP, tx);
      end
    end
    total++; if (frame_count !== 16'd5) begin bad++; $display("FAIL en_fc got=%0d want=5", frame_count); end
    total++; if (rd_ptr !== wr_ptr - 1) begin bad++; $display("FAIL en_pops got=%0d want=%0d", rd_ptr, wr_ptr - 1); end
  endtask

  initial begin
    test_reset;
    test_idle_empty;
    test_reset_mid_frame;
    test_single_a5;
    test_back_to_back;
    test_enable_drop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
